event_encoder_4x2: RTL and testbench
====================================

EVENT_ENCODER_4X2 -- requirements
Module: event_encoder_4x2

Interface
REQ-001 The block SHALL have parameter OVF_STICKY, default 0, meaning 0 = ovf is a one-cycle pulse and 1 = ovf stays high until reset.
REQ-002 Port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 Port rst, input, 1 bit: reset, synchronous and active-high.
REQ-004 Port en, input, 1 bit: event capture enable; when low, y is ignored.
REQ-005 Port y, input, 4 bits: multi-hot event lines; bit i requests code i.
REQ-006 Port x1, output, 1 bit: encoded index LSB.
REQ-007 Port x2, output, 1 bit: encoded index MSB; the index is {x2,x1}.
REQ-008 Port valid, output, 1 bit: {x2,x1} holds a valid encoded event.
REQ-009 Port ready, input, 1 bit: consumer accepts; a transfer occurs when valid and ready are both high at a rising edge.
REQ-010 Port ovf, output, 1 bit: event lost because its bit was already pending.

Function
REQ-011 The block SHALL hold a 4-bit pending register; at each edge with en=1, pending[i] is set for every y[i]=1.
REQ-012 The output stage SHALL be a register loaded only when valid=0 or a transfer occurs.
REQ-013 On load, if pending!=0, the block SHALL select one pending bit per arbitration, drive {x2,x1}=its index, set valid=1, and clear that pending bit in the same edge.
REQ-014 On load with pending==0, the block SHALL set valid=0; x1/x2 hold their previous value.
REQ-015 Selection SHALL use the registered pending value only, giving a minimum latency of 2 edges from y sampled to valid=1.
REQ-016 While valid=1 and ready=0, x1, x2 and valid SHALL remain stable.
REQ-017 Back-to-back transfers SHALL sustain one code per cycle while pending is non-empty.
REQ-018 If y[i]=1 (with en=1) in the same cycle pending[i] is cleared by selection, pending[i] SHALL end set, and ovf SHALL NOT fire.
REQ-019 If y[i]=1 (with en=1) while pending[i]=1 and pending[i] is not being cleared, the event SHALL be dropped and ovf asserted on the next cycle.
REQ-020 Without RR mode, arbitration SHALL be fixed priority, lowest index first.
REQ-021 en=0 SHALL NOT stop the draining of already pending events.

Reset
REQ-022 rst=1 at an edge SHALL clear pending to 0000, valid to 0, x1 and x2 to 0, ovf to 0, and the RR pointer to 3.
REQ-023 rst SHALL override every other input at the same edge, including an in-flight transfer or simultaneous y events, which are discarded.

Configuration
REQ-024 With macro EVENT_ENC_RR_EN defined, arbitration SHALL be round-robin: the search starts at (last granted index + 1) mod 4, and the pointer updates on each load.
REQ-025 With EVENT_ENC_RR_EN defined, the pointer SHALL reset to 3 so that the first search starts at index 0.
REQ-026 With EVENT_ENC_RR_EN undefined, the pointer SHALL not exist and fixed priority per REQ-020 SHALL apply.

Verification
REQ-027 rst for 2 cycles, then y=0100 with en=1 for 1 cycle and ready=1 -> valid=1 and {x2,x1}=10 two edges after y was sampled, then valid=0.
REQ-028 y=1011 for 1 cycle with ready=1, fixed priority -> codes 00, 01, 11 on consecutive cycles, then valid=0.
REQ-029 y=0001 with ready=0 for 5 cycles -> valid=1 and {x2,x1}=00 stable throughout; raising ready -> exactly one transfer.
REQ-030 y=0010 at cycle 0, then again at cycle 1 with ready=0 -> one ovf pulse (OVF_STICKY=0), or ovf stuck high until rst (OVF_STICKY=1).
REQ-031 EVENT_ENC_RR_EN defined, y=1111 held with ready=1 -> code sequence 00, 01, 10, 11, 00, ...; same stimulus undefined -> code 00 repeated.
REQ-032 rst asserted while valid=1 and pending=0110 -> next cycle valid=0, pending=0000, ovf=0, with no further codes emitted.

Source files
------------

// File: rtl/event_encoder_4x2.sv
// Multi-hot event encoder. Events on y are latched into a pending register and
// presented one at a time as a 2-bit index {x2,x1} with a valid/ready handshake.
// Optional feature: define EVENT_ENC_RR_EN for round-robin arbitration; the
// default build uses fixed priority, lowest index first.
module event_encoder_4x2 #(
  parameter int unsigned OVF_STICKY = 0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic [3:0] y,
  input  logic       ready,
  output logic       x1,
  output logic       x2,
  output logic       valid,
  output logic       ovf
);

  logic [3:0] pending_q, pending_d;
  logic [1:0] x_q, x_d;
  logic       valid_q, valid_d;
  logic       ovf_q, ovf_d;

  logic       load;
  logic       grant;
  logic [1:0] sel;
  logic [3:0] clr;
  logic [3:0] req;
  logic       lost;

`ifdef EVENT_ENC_RR_EN
  logic [1:0] ptr_q, ptr_d;
  logic       found;
  logic [1:0] idx;

  // Round-robin search starting one past the last granted index.
  always_comb begin
    sel   = 2'b00;
    found = 1'b0;
    idx   = 2'b00;
    for (int k = 0; k < 4; k++) begin
      idx = ptr_q + 2'(k + 1);
      if (!found && pending_q[idx]) begin
        sel   = idx;
        found = 1'b1;
      end
    end
  end

  // Pointer remembers the last grant so the next search moves past it.
  always_comb begin
    ptr_d = ptr_q;
    if (grant) ptr_d = sel;
  end

  // Pointer register; resets to 3 so the first search begins at index 0.
  always_ff @(posedge clk) begin
    if (rst) ptr_q <= 2'b11;
    else     ptr_q <= ptr_d;
  end
`else
  // Fixed priority: descending scan so the lowest set index wins.
  always_comb begin
    sel = 2'b00;
    for (int k = 3; k >= 0; k--) begin
      if (pending_q[k]) sel = 2'(k);
    end
  end
`endif

  // Output stage loads when empty or when the current code is being taken.
  always_comb begin
    load  = !valid_q || ready;
    grant = load && (pending_q != 4'b0000);
    clr   = grant ? (4'b0001 << sel) : 4'b0000;
    req   = en ? y : 4'b0000;
    // A request is lost only if its bit stays pending through this edge.
    lost  = |(req & pending_q & ~clr);
  end

  // Next-state for pending, output register and overflow flag.
  always_comb begin
    pending_d = (pending_q & ~clr) | req;
    valid_d   = valid_q;
    x_d       = x_q;
    if (load) begin
      valid_d = grant;
      if (grant) x_d = sel;
    end
    if (OVF_STICKY != 0) ovf_d = ovf_q | lost;
    else                 ovf_d = lost;
  end

  // State registers with synchronous active-high reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      pending_q <= 4'b0000;
      x_q       <= 2'b00;
      valid_q   <= 1'b0;
      ovf_q     <= 1'b0;
    end else begin
      pending_q <= pending_d;
      x_q       <= x_d;
      valid_q   <= valid_d;
      ovf_q     <= ovf_d;
    end
  end

  assign x1    = x_q[0];
  assign x2    = x_q[1];
  assign valid = valid_q;
  assign ovf   = ovf_q;

endmodule

// File: tb/tb_event_encoder_4x2.sv
// Scoreboard bench for event_encoder_4x2: stimulus pushes expected codes, a
// monitor pops and compares on every valid&&ready handshake.
module tb_event_encoder_4x2;

  localparam int unsigned OvfSticky = 0;
  localparam int          Hold      = 6;

  logic       clk = 1'b0;
  logic       rst, en, ready;
  logic [3:0] y;
  logic       x1, x2, valid, ovf;

  int errors = 0;
  int checks = 0;
  logic [1:0] sb[$];

  event_encoder_4x2 #(.OVF_STICKY(OvfSticky)) dut (
    .clk   (clk),
    .rst   (rst),
    .en    (en),
    .y     (y),
    .ready (ready),
    .x1    (x1),
    .x2    (x2),
    .valid (valid),
    .ovf   (ovf)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Monitor: a handshake seen at the falling edge completes at the next rising edge.
  always @(negedge clk) begin
    if (!rst && valid && ready) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_code: got %b expected none at %0t", {x2, x1}, $time);
      end else begin
        logic [1:0] e;
        e = sb.pop_front();
        if ({x2, x1} !== e) begin
          errors++;
          $display("FAIL code: got %b expected %b at %0t", {x2, x1}, e, $time);
        end
      end
    end
  end

  initial begin
    rst = 1'b1; en = 1'b0; y = 4'b0000; ready = 1'b0;
    step();
    step();
    check("rst_valid", {3'b0, valid}, 4'd0);
    check("rst_x", {2'b0, x2, x1}, 4'd0);
    check("rst_ovf", {3'b0, ovf}, 4'd0);
    rst = 1'b0;

    // Single event: valid appears after the second edge.
    ready = 1'b1; en = 1'b1; y = 4'b0100;
    sb.push_back(2'b10);
    step();
    y = 4'b0000;
    check("lat_e0_valid", {3'b0, valid}, 4'd0);
    step();
    check("lat_e1_valid", {3'b0, valid}, 4'd1);
    check("lat_e1_x", {2'b0, x2, x1}, 4'b0010);
    step();
    check("lat_e2_valid", {3'b0, valid}, 4'd0);

    // Multi-hot burst drains back-to-back in priority order.
    y = 4'b1011;
    sb.push_back(2'b00); sb.push_back(2'b01); sb.push_back(2'b11);
    step();
    y = 4'b0000;
    step(); step(); step(); step();
    check("burst_done_valid", {3'b0, valid}, 4'd0);

    // Backpressure holds the code stable, then one transfer.
    ready = 1'b0; y = 4'b0001;
    sb.push_back(2'b00);
    step();
    y = 4'b0000;
    step();
    for (int i = 0; i < 5; i++) begin
      check("stall_valid", {3'b0, valid}, 4'd1);
      check("stall_x", {2'b0, x2, x1}, 4'd0);
      step();
    end
    ready = 1'b1;
    step();
    check("stall_release_valid", {3'b0, valid}, 4'd0);

    // Overflow: bit 1 requested twice while the output is stalled.
    ready = 1'b0; y = 4'b0001;
    sb.push_back(2'b00); sb.push_back(2'b01);
    step();
    y = 4'b0000;
    step();
    y = 4'b0010;
    step();
    check("ovf_first_req", {3'b0, ovf}, 4'd0);
    step();
    y = 4'b0000;
    check("ovf_set", {3'b0, ovf}, 4'd1);
    step();
    check("ovf_after", {3'b0, ovf}, (OvfSticky != 0) ? 4'd1 : 4'd0);
    ready = 1'b1;
    step(); step();
    check("ovf_drain_valid", {3'b0, valid}, 4'd0);

    // All lines held high: arbitration order.
    rst = 1'b1; ready = 1'b0;
    step();
    rst = 1'b0;
    check("rst2_ovf", {3'b0, ovf}, 4'd0);
    for (int k = 0; k < Hold + 3; k++) begin
`ifdef EVENT_ENC_RR_EN
      sb.push_back(2'(k % 4));
`else
      sb.push_back((k < Hold) ? 2'd0 : 2'(k - Hold + 1));
`endif
    end
    ready = 1'b1; y = 4'b1111;
    for (int i = 0; i < Hold; i++) step();
    y = 4'b0000;
    for (int i = 0; i < 20 && valid; i++) step();
    check("hold_done_valid", {3'b0, valid}, 4'd0);
    check("hold_sb_empty", 4'(sb.size()), 4'd0);

    // Reset overrides a pending transfer and new events.
    ready = 1'b0; y = 4'b0111;
    step();
    y = 4'b0000;
    step();
    check("pre_rst_valid", {3'b0, valid}, 4'd1);
    rst = 1'b1; ready = 1'b1; y = 4'b1000;
    step();
    rst = 1'b0; y = 4'b0000;
    check("rst3_valid", {3'b0, valid}, 4'd0);
    check("rst3_x", {2'b0, x2, x1}, 4'd0);
    check("rst3_ovf", {3'b0, ovf}, 4'd0);
    for (int i = 0; i < 4; i++) begin
      step();
      check("rst3_quiet", {3'b0, valid}, 4'd0);
    end

    check("final_sb_empty", 4'(sb.size()), 4'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
